// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ram_arbiter
// Purpose : Round-robin arbiter sharing one single-port RAM between two
//           requesters, with a registered RAM interface and per-requester
//           read responses.
// Revision: 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_issue = 2'd1;
  localparam logic [1:0] c_resp  = 2'd2;

  logic [1:0] r_state;
  logic       r_last;   // 1 = requester 1 was granted most recently
  logic       r_owner;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;

  assign w_idle = (r_state == c_idle);
  assign w_gnt0 = w_idle & req0_valid & (~req1_valid | r_last);
  assign w_gnt1 = w_idle & req1_valid & (~req0_valid | ~r_last);

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign busy       = ~w_idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= c_idle;
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (r_state)
        c_idle: begin
          if (w_gnt0 | w_gnt1) begin
            r_owner  <= w_gnt1;
            r_last   <= w_gnt1;
            ram_we   <= w_gnt1 ? req1_we    : req0_we;
            ram_addr <= w_gnt1 ? req1_addr  : req0_addr;
            ram_din  <= w_gnt1 ? req1_wdata : req0_wdata;
            r_state  <= c_issue;
          end
        end
        c_issue: begin
          // ram_we still carries the operation type during ISSUE
          ram_we  <= 1'b0;
          r_state <= ram_we ? c_idle : c_resp;
        end
        c_resp: begin
          if (r_owner) begin
            rsp1_valid <= 1'b1;
            rsp1_rdata <= ram_dout;
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_rdata <= ram_dout;
          end
          r_state <= c_idle;
        end
        default: begin
          ram_we  <= 1'b0;
          r_state <= c_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: AW, 8, address width; SHALL match the single-port RAM depth of 2**AW words.
REQ-002 Parameter: DW, 8, data width; SHALL match the RAM word width.
REQ-003 Port: clk  in  1  single clock; all state updates on posedge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-005 Port: req0_valid / req1_valid  in  1  requester N has a pending transaction.
REQ-006 Port: req0_we / req1_we  in  1  1 = write, 0 = read.
REQ-007 Port: req0_addr / req1_addr  in  AW  target address.
REQ-008 Port: req0_wdata / req1_wdata  in  DW  write data.
REQ-009 Port: req0_ready / req1_ready  out  1  grant; the transaction is accepted at the posedge where valid and ready are both 1.
REQ-010 Port: rsp0_valid / rsp1_valid  out  1  one-cycle pulse; read data is valid.
REQ-011 Port: rsp0_rdata / rsp1_rdata  out  DW  read data; holds its value between pulses.
REQ-012 Port: ram_we  out  1  RAM write enable (registered).
REQ-013 Port: ram_addr  out  AW  RAM address (registered).
REQ-014 Port: ram_din  out  DW  RAM write data (registered).
REQ-015 Port: ram_dout  in  DW  RAM registered read data; valid one cycle after a read edge.
REQ-016 Port: busy  out  1  1 whenever the state is not IDLE.

Function
REQ-017 FSM SHALL have three states, all others unreachable:
- IDLE: accept a request.
- ISSUE: drive the RAM for one cycle.
- RESP: capture read data.
REQ-018 reqN_ready SHALL be combinational: high only in IDLE, only for the arbitration winner, and never for both requesters in the same cycle.
REQ-019 Arbitration SHALL be round-robin.
- Only one valid: that requester wins.
- Both valid: the requester not granted last wins.
- The last-grant pointer updates only on a handshake.
REQ-020 On handshake: latch we/addr/wdata into ram_we/ram_addr/ram_din, record the owner, go IDLE->ISSUE.
REQ-021 ISSUE lasts exactly one cycle; RAM write or read occurs at its closing edge.
- Write: ram_we<=0, go ISSUE->IDLE.
- Read: go ISSUE->RESP.
REQ-022 ram_we SHALL be 1 only during ISSUE of a write; 0 in every other cycle.
REQ-023 ram_addr and ram_din SHALL hold their last values outside ISSUE.
REQ-024 RESP closing edge:
- rspN_rdata<=ram_dout and rspN_valid<=1 for the owner only.
- The other requester's rsp outputs are unchanged.
- Go RESP->IDLE.
REQ-025 rspN_valid SHALL be high exactly one cycle per accepted read; writes produce no response.
REQ-026 Latency from handshake edge: write committed at edge +1; read response visible in the cycle after edge +2.
REQ-027 Throughput: the next handshake is possible in the first IDLE cycle.
- Back-to-back writes: one every 2 cycles.
- Back-to-back reads: one every 3 cycles.
REQ-028 A requester dropping valid before its handshake SHALL cancel with no RAM access and no pointer change.
REQ-029 Transactions SHALL execute strictly in grant order; a read of an address written by an earlier grant returns the new data.
REQ-030 An address of all-ones (2**AW-1) is legal; no wrap-around logic is required.
REQ-031 Inputs sampled outside an IDLE handshake SHALL be ignored.

Reset
REQ-032 rst=0 SHALL act immediately, without waiting for a clock edge:
- State: IDLE.
- ram_we: 0; ram_addr, ram_din: 0.
- rsp0/1_valid: 0; rsp0/1_rdata: 0.
- busy: 0.
- Pointer: requester 1 marked as last granted.
REQ-033 Reset asserted during ISSUE or RESP SHALL abort the transaction.
- No write is performed after assertion.
- No response is issued for an aborted read.
REQ-034 The first posedge with rst=1 may accept a request; requester 0 wins if both are valid.

Verification
REQ-035 Reset release, req0 write addr 0x10 data 0xA5 -> req0_ready=1 in first cycle; ram_we=1 with addr 0x10 / din 0xA5 for exactly one cycle; busy=1 for one cycle.
REQ-036 req0 read addr 0x10 after REQ-035 -> rsp0_valid single pulse 3 cycles after the handshake cycle; rsp0_rdata=0xA5; rsp1_valid stays 0.
REQ-037 Both valid continuously, reads of 0x01 (req0) and 0x02 (req1) -> grants alternate 0,1,0,1 starting with 0; each owner receives its own data.
REQ-038 req1 writes 0xFF to 0xFF, then req0 reads 0xFF in the next grant -> rsp0_rdata=0xFF; address 0xFF accessed without error.
REQ-039 rst=0 driven mid-RESP of a read -> ram_we=0, busy=0, rsp valids=0 immediately; no response pulse after release.
REQ-040 req1_valid high for one cycle while state is ISSUE, then dropped -> no grant to req1, no RAM access for req1, pointer unchanged.
